tlp_crc_append: RTL and testbench

TLP_CRC_APPEND -- requirements
Module: tlp_crc_append

---
 rtl/tlp_crc_append.sv | 140 ++++++++++++++
 tb/tb_tlp_crc_append.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlp_crc_append.sv
// Appends a bit-serial CRC to a TLP word, folding one byte per cycle, and
// optionally stamps a 12-bit sequence number into the top 16 bits.
module tlp_crc_append #(
    parameter int                DATA_W = 128,
    parameter int                CRC_W  = 16,
    parameter logic [CRC_W-1:0]  POLY   = 16'h1021,
    parameter logic [CRC_W-1:0]  INIT   = 16'hFFFF,
    parameter bit                SEQ_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] crc_out,
    output logic [11:0]       seq_num,
    output logic              busy
);
    localparam int WORK_W = DATA_W - CRC_W;
    localparam int N      = WORK_W / 8;
    localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WORK_W-1:0]   work_q, work_d;
    logic [WORK_W-1:0]   shift_q, shift_d;
    logic [CRC_W-1:0]    crc_q, crc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   crc_out_q, crc_out_d;
    logic [11:0]         seq_q, seq_d;
    logic [WORK_W-1:0]   accept_word;
    logic [CRC_W-1:0]    crc_fold;
    logic                unused_low_bits;

    function automatic logic [CRC_W-1:0] fold_byte(input logic [CRC_W-1:0] crc_in,
                                                   input logic [7:0]       data_byte);
        logic [CRC_W-1:0] c;
        logic             fb;
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[CRC_W-1] ^ data_byte[i];
            c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        return c;
    endfunction

    // The low CRC_W bits of data_in are reserved for the CRC and carry nothing.
    assign unused_low_bits = ^data_in[CRC_W-1:0];

    always_comb begin
        accept_word = data_in[DATA_W-1:CRC_W];
        if (SEQ_EN) begin
            accept_word[WORK_W-1 -: 16] = {4'b0000, seq_q};
        end
    end

    // shift_q presents the next byte to fold at its top; work_q keeps the original word.
    assign crc_fold = fold_byte(crc_q, shift_q[WORK_W-1 -: 8]);

    // Handshakes: a TLP is taken on a clock edge where in_valid && in_ready, and
    // a result is consumed on an edge where out_valid && out_ready. Once
    // out_valid rises, crc_out and seq_num hold until that consuming edge.
    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        shift_d     = shift_q;
        crc_d       = crc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        crc_out_d   = crc_out_q;
        seq_d       = seq_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = accept_word;
                    shift_d = accept_word;
                    crc_d   = INIT;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                crc_d   = crc_fold;
                shift_d = shift_q << 8;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    out_valid_d = 1'b1;
                    crc_out_d   = {work_q, crc_fold};
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    seq_d       = seq_q + 12'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            work_q      <= '0;
            shift_q     <= '0;
            crc_q       <= INIT;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            crc_out_q   <= '0;
            seq_q       <= '0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            shift_q     <= shift_d;
            crc_q       <= crc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            crc_out_q   <= crc_out_d;
            seq_q       <= seq_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign crc_out   = crc_out_q;
    assign seq_num   = seq_q;

endmodule

// File: tb/tb_tlp_crc_append.sv
// Bench for tlp_crc_append: default build, an 88-bit check-value build without
// sequence stamping, and a 32-bit build used to walk the sequence counter round.
module tb_tlp_crc_append;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] data_in, crc_out;
    logic [11:0]  seq_num;

    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [87:0]  b_data_in, b_crc_out;
    logic [11:0]  b_seq_num;

    logic         c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_busy;
    logic [31:0]  c_data_in, c_crc_out;
    logic [11:0]  c_seq_num;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           exp_seq  = 0;
    logic [127:0] exp_q[$];

    tlp_crc_append dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
        .out_valid(out_valid), .out_ready(out_ready), .crc_out(crc_out),
        .seq_num(seq_num), .busy(busy)
    );

    tlp_crc_append #(.DATA_W(88), .SEQ_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .data_in(b_data_in),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .crc_out(b_crc_out),
        .seq_num(b_seq_num), .busy(b_busy)
    );

    tlp_crc_append #(.DATA_W(32), .SEQ_EN(1'b1)) dut_c (
        .clk(clk), .rst(rst),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .data_in(c_data_in),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .crc_out(c_crc_out),
        .seq_num(c_seq_num), .busy(c_busy)
    );

    // CRC-16 over the low nbytes*8 bits of msg, message MSB first, no reflection.
    function automatic logic [15:0] ref_crc(input logic [111:0] msg, input int nbytes);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = nbytes * 8 - 1; i >= 0; i--) begin
            fb = c[15] ^ msg[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    function automatic logic [127:0] ref_word(input logic [127:0] d, input int seq);
        logic [111:0] payload;
        logic [11:0]  s;
        s       = 12'(seq);
        payload = {4'b0000, s, d[111:16]};
        return {payload, ref_crc(payload, 14)};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Driver/monitor for the default build: offers one TLP, waits for the result,
    // stalls, then consumes it. lat counts cycles from the accept cycle.
    task automatic run_a(input logic [127:0] d, input int stall,
                         output logic [127:0] got, output int lat, output bit to);
        int t;
        to  = 1'b0;
        got = '0;
        lat = 0;
        t   = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            to = 1'b1;
            return;
        end
        in_valid = 1'b1;
        data_in  = d;
        @(negedge clk);
        in_valid = 1'b0;
        data_in  = rand128();
        lat      = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            to = 1'b1;
            return;
        end
        got = crc_out;
        repeat (stall) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_b(input logic [87:0] d, output logic [87:0] got,
                         output int lat, output bit to);
        to  = 1'b0;
        got = '0;
        lat = 0;
        if (!b_in_ready) begin
            to = 1'b1;
            return;
        end
        b_in_valid = 1'b1;
        b_data_in  = d;
        @(negedge clk);
        b_in_valid = 1'b0;
        b_data_in  = {$urandom, $urandom, 24'($urandom)};
        lat        = 1;
        while (!b_out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!b_out_valid) begin
            to = 1'b1;
            return;
        end
        got         = b_crc_out;
        b_out_ready = 1'b1;
        @(negedge clk);
        b_out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++;
        if (seq_num !== 12'd0) begin n_fail++; $display("FAIL reset_seq got=%h exp=0", seq_num); end
        n_checks++;
        if (crc_out !== 128'd0) begin n_fail++; $display("FAIL reset_crc_out got=%h exp=0", crc_out); end
        n_checks++;
        if (b_in_ready !== 1'b1 || c_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_other_ready got=%b%b exp=11", b_in_ready, c_in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle got ready=%b busy=%b exp ready=1 busy=0", in_ready, busy);
        end
        exp_seq = 0;
    endtask

    task automatic test_check_value;
        logic [87:0] d, got;
        int          lat;
        bit          to;
        d = {72'h313233343536373839, 16'($urandom)};
        run_b(d, got, lat, to);
        n_checks++;
        if (to) begin
            n_fail++;
            $display("FAIL check_value_timeout got no out_valid exp out_valid within 100 cycles");
        end else begin
            n_checks++;
            if (lat != 10) begin n_fail++; $display("FAIL check_value_latency got=%0d exp=10", lat); end
            n_checks++;
            if (got[15:0] !== 16'h29B1) begin n_fail++; $display("FAIL check_value_crc got=%h exp=29b1", got[15:0]); end
            n_checks++;
            if (got[87:16] !== d[87:16]) begin n_fail++; $display("FAIL check_value_payload got=%h exp=%h", got[87:16], d[87:16]); end
            n_checks++;
            if (b_seq_num !== 12'd1) begin n_fail++; $display("FAIL check_value_seq got=%h exp=001", b_seq_num); end
        end
        // A random payload through the same no-stamp build.
        d = {$urandom, $urandom, 24'($urandom)};
        run_b(d, got, lat, to);
        n_checks++;
        if (to || got !== {d[87:16], ref_crc({40'd0, d[87:16]}, 9)}) begin
            n_fail++;
            $display("FAIL random_88_word got=%h exp=%h", got, {d[87:16], ref_crc({40'd0, d[87:16]}, 9)});
        end
    endtask

    task automatic test_seq_insert;
        logic [127:0] d, got, exp;
        int           lat;
        bit           to;
        for (int k = 0; k < 3; k++) begin
            d = rand128();
            exp_q.push_back(ref_word(d, exp_seq));
            run_a(d, $urandom_range(0, 3), got, lat, to);
            exp = exp_q.pop_front();
            n_checks++;
            if (to) begin
                n_fail++;
                $display("FAIL seq_insert_timeout tlp=%0d got no out_valid exp out_valid", k);
            end else begin
                n_checks++;
                if (got[127:112] !== 16'(k)) begin n_fail++; $display("FAIL seq_field tlp=%0d got=%h exp=%h", k, got[127:112], 16'(k)); end
                n_checks++;
                if (got !== exp) begin n_fail++; $display("FAIL seq_word tlp=%0d got=%h exp=%h", k, got, exp); end
                n_checks++;
                if (lat != 15) begin n_fail++; $display("FAIL seq_latency tlp=%0d got=%0d exp=15", k, lat); end
                exp_seq++;
                n_checks++;
                if (seq_num !== 12'(exp_seq)) begin n_fail++; $display("FAIL seq_after tlp=%0d got=%h exp=%h", k, seq_num, 12'(exp_seq)); end
            end
        end
    endtask

    task automatic test_backpressure;
        logic [127:0] d, snap, got, exp;
        int           t, lat;
        bit           to;
        d        = rand128();
        exp      = ref_word(d, exp_seq);
        in_valid = 1'b1;
        data_in  = d;
        @(negedge clk);
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (!out_valid) begin
            n_fail++;
            $display("FAIL backpressure_timeout got no out_valid exp out_valid");
        end else begin
            snap = crc_out;
            n_checks++;
            if (snap !== exp) begin n_fail++; $display("FAIL backpressure_word got=%h exp=%h", snap, exp); end
            for (int i = 0; i < 5; i++) begin
                in_valid = 1'b1;
                data_in  = rand128();
                @(negedge clk);
                n_checks++;
                if (out_valid !== 1'b1 || crc_out !== snap || in_ready !== 1'b0 || seq_num !== 12'(exp_seq)) begin
                    n_fail++;
                    $display("FAIL stall_hold cyc=%0d got valid=%b ready=%b seq=%h word=%h exp valid=1 ready=0 seq=%h word=%h",
                             i, out_valid, in_ready, seq_num, crc_out, 12'(exp_seq), snap);
                end
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            exp_seq++;
            n_checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0 || seq_num !== 12'(exp_seq)) begin
                n_fail++;
                $display("FAIL release got ready=%b valid=%b seq=%h exp ready=1 valid=0 seq=%h",
                         in_ready, out_valid, seq_num, 12'(exp_seq));
            end
        end
        d   = rand128();
        exp = ref_word(d, exp_seq);
        run_a(d, 0, got, lat, to);
        exp_seq++;
        n_checks++;
        if (to || got !== exp) begin n_fail++; $display("FAIL after_stall_word got=%h exp=%h", got, exp); end
    endtask

    task automatic test_wrap;
        int          k, cyc;
        logic [15:0] field;
        logic [31:0] exp;
        k   = 0;
        cyc = 0;
        c_in_valid  = 1'b1;
        c_out_ready = 1'b1;
        while (k < 4097 && cyc < 4097 * 4 + 100) begin
            c_data_in = $urandom;
            @(negedge clk);
            cyc++;
            if (c_out_valid) begin
                field = {4'b0000, 12'(k)};
                exp   = {field, ref_crc({96'd0, field}, 2)};
                n_checks++;
                if (c_crc_out !== exp) begin n_fail++; $display("FAIL wrap_word out=%0d got=%h exp=%h", k + 1, c_crc_out, exp); end
                n_checks++;
                if (c_seq_num !== 12'(k)) begin n_fail++; $display("FAIL wrap_seq out=%0d got=%h exp=%h", k + 1, c_seq_num, 12'(k)); end
                if (k == 4096) c_in_valid = 1'b0;
                k++;
            end
        end
        n_checks++;
        if (k != 4097) begin n_fail++; $display("FAIL wrap_count got=%0d exp=4097", k); end
        @(negedge clk);
        c_out_ready = 1'b0;
        c_in_valid  = 1'b0;
        n_checks++;
        if (c_seq_num !== 12'd1 || c_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_final got seq=%h ready=%b exp seq=001 ready=1", c_seq_num, c_in_ready);
        end
    endtask

    task automatic test_reset_mid_calc;
        logic [127:0] d, got, exp;
        int           lat;
        bit           seen;
        bit           to;
        d        = rand128();
        in_valid = 1'b1;
        data_in  = d;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_calc_state got busy=%b ready=%b valid=%b exp busy=1 ready=0 valid=0", busy, in_ready, out_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_seq = 0;
        n_checks++;
        if (out_valid !== 1'b0 || seq_num !== 12'd0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_calc_reset got valid=%b seq=%h ready=%b busy=%b exp valid=0 seq=000 ready=1 busy=0",
                     out_valid, seq_num, in_ready, busy);
        end
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL discarded_tlp got out_valid=1 exp out_valid=0"); end
        d   = rand128();
        exp = ref_word(d, exp_seq);
        run_a(d, 0, got, lat, to);
        n_checks++;
        if (to || lat != 15 || got !== exp) begin
            n_fail++;
            $display("FAIL post_reset_tlp got lat=%0d word=%h exp lat=15 word=%h", lat, got, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got no finish exp finish before 1000000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        data_in     = '0;
        b_in_valid  = 1'b0;
        b_out_ready = 1'b0;
        b_data_in   = '0;
        c_in_valid  = 1'b0;
        c_out_ready = 1'b0;
        c_data_in   = '0;
        test_reset();
        test_check_value();
        test_seq_insert();
        test_backpressure();
        test_wrap();
        test_reset_mid_calc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
